// File: rtl/fp_alu_arbiter_if.sv
// Bus bundle for fp_alu_arbiter: two requesters, the shared FP unit and the
// response channel. The slave modport is the arbiter's view; the master
// modport is the view of whoever drives requests and models the FP unit.
interface fp_alu_arbiter_if;
  logic        req0;
  logic        req1;
  logic        op0;
  logic        op1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic        alu_en;
  logic        alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_ready;
  logic        busy;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_result, rsp_ready,
    output gnt0, gnt1, alu_en, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, busy
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_result, rsp_ready,
    input  gnt0, gnt1, alu_en, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/fp_alu_arbiter.sv
// fp_alu_arbiter: shares one FP add/sub unit between two requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// ALU_LAT (1..15) is the shared unit's latency from operand issue to result.
// Optional feature: define FP_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// without it requester 0 always wins ties and no last_id state is built.
module fp_alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_alu_arbiter_if.slave   bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_id;
  logic               r_gnt0;
  logic               r_gnt1;
  logic               r_alu_en;
  logic               r_alu_op;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [DATA_W-1:0]  r_rsp_result;
  logic               r_busy;

  logic               w_any_req;
  logic               w_win_id;
  logic               w_win_op;
  logic [DATA_W-1:0]  w_win_a;
  logic [DATA_W-1:0]  w_win_b;

`ifdef FP_ARB_ROUND_ROBIN_EN
  logic               r_last_id;
`endif

  // Pick the winner among the requests sampled this cycle.
  always_comb begin
    w_any_req = bus.req0 | bus.req1;
    w_win_id  = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef FP_ARB_ROUND_ROBIN_EN
      w_win_id = ~r_last_id;
`else
      w_win_id = 1'b0;
`endif
    end else if (bus.req1) begin
      w_win_id = 1'b1;
    end
    w_win_op = w_win_id ? bus.op1 : bus.op0;
    w_win_a  = w_win_id ? bus.a1  : bus.a0;
    w_win_b  = w_win_id ? bus.b1  : bus.b0;
  end

`ifdef FP_ARB_ROUND_ROBIN_EN
  // Remember the most recent grant; reset favours requester 0 on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_id <= 1'b1;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_id <= w_win_id;
    end
  end
`endif

  // Control FSM with registered outputs; grants are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_id         <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_alu_en     <= 1'b0;
      r_alu_op     <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_id     <= w_win_id;
            r_alu_op <= w_win_op;
            r_alu_a  <= w_win_a;
            r_alu_b  <= w_win_b;
            r_gnt0   <= ~w_win_id;
            r_gnt1   <= w_win_id;
            r_alu_en <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_LOAD;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_id     <= r_id;
            r_rsp_valid  <= 1'b1;
            r_alu_en     <= 1'b0;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          // Returning to IDLE costs one edge, so no grant on the leaving edge.
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0       = r_gnt0;
  assign bus.gnt1       = r_gnt1;
  assign bus.alu_en     = r_alu_en;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed bench for fp_alu_arbiter: one instance at ALU_LAT=1 and one at
// ALU_LAT=3, each with a small FP-unit model whose result only becomes
// valid after the configured latency.
module tb_fp_alu_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fp_alu_arbiter_if if1 ();
  fp_alu_arbiter_if if3 ();

  fp_alu_arbiter #(.ALU_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  fp_alu_arbiter #(.ALU_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  always #5 clk = ~clk;

  // Known FP results for the vectors used below.
  function automatic logic [31:0] fp_model(input logic op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (!op && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if ( op && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (!op && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    return 32'h0000_0000;
  endfunction

  // FP unit models: result is garbage until alu_en has been seen for LAT edges.
  logic [3:0] m1_cnt;
  logic [3:0] m3_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m1_cnt <= '0;
    else if (!if1.alu_en) m1_cnt <= '0;
    else if (m1_cnt != 4'd15) m1_cnt <= m1_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m3_cnt <= '0;
    else if (!if3.alu_en) m3_cnt <= '0;
    else if (m3_cnt != 4'd15) m3_cnt <= m3_cnt + 4'd1;
  end

  assign if1.alu_result = (m1_cnt >= 4'd1) ? fp_model(if1.alu_op, if1.alu_a, if1.alu_b)
                                           : 32'hDEAD_BEEF;
  assign if3.alu_result = (m3_cnt >= 4'd3) ? fp_model(if3.alu_op, if3.alu_a, if3.alu_b)
                                           : 32'hDEAD_BEEF;

  function automatic logic [127:0] outs1();
    return 128'({if1.gnt0, if1.gnt1, if1.alu_en, if1.alu_op, if1.alu_a, if1.alu_b,
                 if1.rsp_valid, if1.rsp_id, if1.rsp_result, if1.busy});
  endfunction

  function automatic logic [127:0] outs3();
    return 128'({if3.gnt0, if3.gnt1, if3.alu_en, if3.alu_op, if3.alu_a, if3.alu_b,
                 if3.rsp_valid, if3.rsp_id, if3.rsp_result, if3.busy});
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int       en_cycles;
    logic     saw;
    int       ng;
    logic [1:0] gid [4];
    int       gcyc [4];
    logic     last_gid;
    logic [1:0] exp_gid [4];

    clk = 1'b0; rst_n = 1'b0;
    n_checks = 0; n_fail = 0;
    if1.req0 = 0; if1.req1 = 0; if1.op0 = 0; if1.op1 = 0;
    if1.a0 = '0; if1.b0 = '0; if1.a1 = '0; if1.b1 = '0; if1.rsp_ready = 0;
    if3.req0 = 0; if3.req1 = 0; if3.op0 = 0; if3.op1 = 0;
    if3.a0 = '0; if3.b0 = '0; if3.a1 = '0; if3.b1 = '0; if3.rsp_ready = 0;

    // Reset state
    step(); step();
    check("rst_outs_lat1", outs1(), 128'd0);
    check("rst_outs_lat3", outs3(), 128'd0);

    // LAT=1 single add from requester 0, first edge after reset release arbitrates
    if1.op0 = 1'b0; if1.a0 = 32'h3F80_0000; if1.b0 = 32'h4000_0000; if1.req0 = 1'b1;
    rst_n = 1'b1;
    step();
    check("t1_gnt0", 128'(if1.gnt0), 128'd1);
    check("t1_gnt1", 128'(if1.gnt1), 128'd0);
    check("t1_alu_en_issue", 128'(if1.alu_en), 128'd1);
    check("t1_alu_a", 128'(if1.alu_a), 128'h3F80_0000);
    check("t1_alu_b", 128'(if1.alu_b), 128'h4000_0000);
    check("t1_busy", 128'(if1.busy), 128'd1);
    if1.req0 = 1'b0;
    step();
    check("t1_gnt0_pulse", 128'(if1.gnt0), 128'd0);
    check("t1_valid_early", 128'(if1.rsp_valid), 128'd0);
    check("t1_alu_en_wait", 128'(if1.alu_en), 128'd1);
    step();
    check("t1_valid", 128'(if1.rsp_valid), 128'd1);
    check("t1_rsp_id", 128'(if1.rsp_id), 128'd0);
    check("t1_rsp_result", 128'(if1.rsp_result), 128'h4040_0000);
    check("t1_alu_en_resp", 128'(if1.alu_en), 128'd0);
    if1.rsp_ready = 1'b1;
    step();
    check("t1_valid_clear", 128'(if1.rsp_valid), 128'd0);
    check("t1_idle_busy", 128'(if1.busy), 128'd0);
    // A request dropped before the edge is ignored
    #1 if1.req1 = 1'b1;
    #2 if1.req1 = 1'b0;
    step();
    check("t1_glitch_gnt1", 128'(if1.gnt1), 128'd0);
    check("t1_glitch_busy", 128'(if1.busy), 128'd0);

    // LAT=3 subtract from requester 1 with a stalled consumer
    if3.op1 = 1'b1; if3.a1 = 32'h4040_0000; if3.b1 = 32'h3F80_0000; if3.req1 = 1'b1;
    if3.rsp_ready = 1'b0;
    step();
    check("t2_gnt1", 128'(if3.gnt1), 128'd1);
    check("t2_gnt0", 128'(if3.gnt0), 128'd0);
    check("t2_alu_op", 128'(if3.alu_op), 128'd1);
    en_cycles = int'(if3.alu_en);
    if3.req1 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      en_cycles += int'(if3.alu_en);
      check("t2_valid_early", 128'(if3.rsp_valid), 128'd0);
    end
    step();
    en_cycles += int'(if3.alu_en);
    check("t2_valid", 128'(if3.rsp_valid), 128'd1);
    check("t2_rsp_id", 128'(if3.rsp_id), 128'd1);
    check("t2_rsp_result", 128'(if3.rsp_result), 128'h4000_0000);
    check("t2_alu_en_cycles", 128'(en_cycles), 128'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_valid", 128'(if3.rsp_valid), 128'd1);
      check("t2_stall_result", 128'(if3.rsp_result), 128'h4000_0000);
      check("t2_stall_id", 128'(if3.rsp_id), 128'd1);
    end
    if3.rsp_ready = 1'b1;
    step();
    check("t2_idle_busy", 128'(if3.busy), 128'd0);
    check("t2_valid_clear", 128'(if3.rsp_valid), 128'd0);
    check("t2_hold_op", 128'(if3.alu_op), 128'd1);
    check("t2_hold_a", 128'(if3.alu_a), 128'h4040_0000);

    // LAT=1 both requesters held high continuously
    if1.op0 = 1'b0; if1.a0 = 32'h4000_0000; if1.b0 = 32'h4000_0000;
    if1.op1 = 1'b1; if1.a1 = 32'h4040_0000; if1.b1 = 32'h3F80_0000;
    if1.rsp_ready = 1'b1;
    if1.req0 = 1'b1; if1.req1 = 1'b1;
    ng = 0; last_gid = 1'b0;
    for (int k = 0; k < 4; k++) begin gid[k] = 2'd2; gcyc[k] = 0; end
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      check("t3_gnt_exclusive", 128'(if1.gnt0 & if1.gnt1), 128'd0);
      if ((if1.gnt0 || if1.gnt1) && ng < 4) begin
        gid[ng]  = {1'b0, if1.gnt1};
        gcyc[ng] = cyc;
        ng++;
      end
      if (if1.gnt0 || if1.gnt1) last_gid = if1.gnt1;
      if (if1.rsp_valid) begin
        check("t3_rsp_id", 128'(if1.rsp_id), 128'(last_gid));
        check("t3_rsp_result", 128'(if1.rsp_result),
              last_gid ? 128'h4000_0000 : 128'h4080_0000);
      end
    end
`ifdef FP_ARB_ROUND_ROBIN_EN
    exp_gid[0] = 2'd0; exp_gid[1] = 2'd1; exp_gid[2] = 2'd0; exp_gid[3] = 2'd1;
`else
    exp_gid[0] = 2'd0; exp_gid[1] = 2'd0; exp_gid[2] = 2'd0; exp_gid[3] = 2'd0;
`endif
    for (int k = 0; k < 4; k++) check("t3_grant_order", 128'(gid[k]), 128'(exp_gid[k]));
    for (int k = 1; k < 4; k++) check("t3_grant_spacing", 128'(gcyc[k] - gcyc[k-1]), 128'd4);
    if1.req0 = 1'b0; if1.req1 = 1'b0;
    repeat (6) step();

    // LAT=3 reset pulse while in WAIT aborts the operation
    if3.op0 = 1'b0; if3.a0 = 32'h3F80_0000; if3.b0 = 32'h4000_0000; if3.req0 = 1'b1;
    step();
    check("t4_gnt0", 128'(if3.gnt0), 128'd1);
    if3.req0 = 1'b0;
    step(); step();
    check("t4_in_wait", 128'(if3.alu_en), 128'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t4_rst_outs_lat3", outs3(), 128'd0);
    check("t4_rst_outs_lat1", outs1(), 128'd0);
    #2 rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      step();
      saw = saw | if3.rsp_valid | if3.busy;
    end
    check("t4_no_stale_rsp", 128'(saw), 128'd0);
    if3.req0 = 1'b1;
    step();
    check("t4_regrant", 128'(if3.gnt0), 128'd1);
    if3.req0 = 1'b0;
    step(); step(); step();
    check("t4_valid_early", 128'(if3.rsp_valid), 128'd0);
    step();
    check("t4_valid", 128'(if3.rsp_valid), 128'd1);
    check("t4_rsp_id", 128'(if3.rsp_id), 128'd0);
    check("t4_rsp_result", 128'(if3.rsp_result), 128'h4040_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
